// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction word type, loader FSM states and the
// big-endian byte insert helper used by the boot loader.
package mips_pkg;

  localparam int BYTES_PER_WORD = 4;

  // Instruction word, shared with the core's fetch path.
  typedef logic [31:0] word_t;

  // Boot loader FSM states. CHECK is only reachable in checksum builds.
  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
    LD_CHECK = 3'd3,
    LD_DONE  = 3'd4
  } loader_state_e;

  // Place byte number idx of a word big-endian: byte 0 is the MSB.
  function automatic word_t insert_byte(input word_t w, input logic [1:0] idx,
                                        input logic [7:0] b);
    word_t r;
    r = w;
    r[(BYTES_PER_WORD - 1 - int'(idx)) * 8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// master: byte source / memory side. slave: the loader itself.
interface imem_loader_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  word_t             imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Collects four stream bytes into one big-endian instruction word.
// word_next is the register contents with the current byte inserted;
// word_full flags the accept that completes a word.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [7:0] byte_in,
  output word_t      word_next,
  output logic       word_full
);

  logic [1:0] byte_idx;
  word_t      word_q;

  assign word_next = insert_byte(word_q, byte_idx, byte_in);
  assign word_full = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

  // Byte index and partial word; index wraps to 0 after the fourth byte.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values; blocking here would create order-dependent races.
    if (rst || clear) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: streams bytes into instruction memory as
// big-endian words and holds the core in reset until the load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte
// checked in the CHECK state; a mismatch raises error and returns to IDLE.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [ADDR_W:0] num_words,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e END_STATE = LD_CHECK;
`else
  localparam loader_state_e END_STATE = LD_DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   num_words_q;
  logic [ADDR_W:0]   num_words_clamped;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  word_t             wdata_q;
  word_t             word_next;
  logic              word_full;
  logic              start_ok;
  logic              byte_fire;
  logic              payload_fire;
  logic              last_word;

  assign num_words_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign start_ok     = start && ((state_q == LD_IDLE) || (state_q == LD_DONE));
  assign byte_fire    = bus.byte_valid && bus.byte_ready;
  assign payload_fire = byte_fire && (state_q == LD_RECV);
  assign cnt_inc      = word_cnt_q + ONE;
  assign last_word    = (cnt_inc == num_words_q);

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .byte_en   (payload_fire),
    .byte_in   (bus.byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       error_q;
  logic       trailer_ok;

  assign trailer_ok = (bus.byte_data == xor_q);

  // Running XOR of payload bytes and sticky checksum error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else if (start_ok) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (payload_fire) xor_q <= xor_q ^ bus.byte_data;
      if (byte_fire && (state_q == LD_CHECK) && !trailer_ok) error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Next-state logic for the load session.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) state_d = (num_words_clamped == '0) ? END_STATE : LD_RECV;
      end
      LD_RECV: begin
        if (word_full) state_d = LD_WRITE;
      end
      LD_WRITE: begin
        state_d = last_word ? END_STATE : LD_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_fire) state_d = trailer_ok ? LD_DONE : LD_IDLE;
      end
`endif
      default: state_d = LD_IDLE;
    endcase
  end

  // State, word counter, latched length and held write address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        word_cnt_q  <= '0;
        num_words_q <= num_words_clamped;
      end else if (state_q == LD_WRITE) begin
        word_cnt_q <= cnt_inc;
      end
      // Captured when the word completes so the values are stable during WRITE and held afterwards.
      if (word_full) begin
        addr_q  <= word_cnt_q[ADDR_W-1:0];
        wdata_q <= word_next;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state_q == LD_RECV) || (state_q == LD_CHECK);
`else
  assign bus.byte_ready = (state_q == LD_RECV);
`endif
  assign bus.imem_we    = (state_q == LD_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = (state_q != LD_DONE);
  assign busy           = (state_q == LD_RECV) || (state_q == LD_WRITE) ||
                          (state_q == LD_CHECK);
  assign done           = (state_q == LD_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load sessions, hand-written
// reset/checksum sequences and randomized sessions, all checked against a
// word-list model built from the byte stream.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDR_W:0]  num_words;
  logic             core_rst, busy, done, error;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .bus       (ifc),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    int          nw;
    int          gap;      // 0 back-to-back, 1 alternate cycles, 2 random stalls
    int          glitch;   // byte index before which a stray start is pulsed, -1 none
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_writes;
  } vec_t;

  wr_t        writes[$];
  logic [7:0] payload[$];
  int         cyc = 0;
  int         last_we_cyc = 0;
  int         done_rise_cyc = 0;
  int         ready_in_write = 0;
  logic       done_q = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ifc.imem_we) begin
      writes.push_back(wr_t'{addr: ifc.imem_addr, data: ifc.imem_wdata});
      last_we_cyc <= cyc;
      if (ifc.byte_ready) ready_in_write <= ready_in_write + 1;
    end
    if (done && !done_q) done_rise_cyc <= cyc;
    done_q <= done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one byte until accepted; returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    while (!ifc.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("byte_ready timeout", 32'd0, 32'd1);
    @(negedge clk);
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'($urandom);
  endtask

  // One full session; payload holds any fixed leading bytes, the rest is random.
  task automatic run_load(input int nw, input int gap, input int glitch,
                          input int exp_writes, input string tag);
    int          eff, ws, rw, n;
    logic [7:0]  x;
    logic [31:0] exp_word;
    eff = (nw > MAX_WORDS) ? MAX_WORDS : nw;
    while (payload.size() < eff * 4) payload.push_back(8'($urandom_range(0, 255)));
    while (payload.size() > eff * 4) void'(payload.pop_back());
    x = 8'h00;
    foreach (payload[i]) x ^= payload[i];
    ws = writes.size();
    rw = ready_in_write;

    start     = 1'b1;
    num_words = (ADDR_W + 1)'(nw);
    @(negedge clk);
    start     = 1'b0;
    num_words = (ADDR_W + 1)'($urandom);
    check($sformatf("%s error after start", tag), error, 0);
    if (eff > 0) begin
      check($sformatf("%s byte_ready after start", tag), ifc.byte_ready, 1);
      check($sformatf("%s busy after start", tag), busy, 1);
      check($sformatf("%s core_rst during load", tag), core_rst, 1);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    else begin
      check($sformatf("%s zero-length done", tag), done, 1);
      check($sformatf("%s zero-length core_rst", tag), core_rst, 0);
    end
`endif

    for (int i = 0; i < payload.size(); i++) begin
      if (i == glitch) begin
        start     = 1'b1;
        num_words = (ADDR_W + 1)'(5);
        @(negedge clk);
        start     = 1'b0;
      end
      send_byte(payload[i]);
      if (gap == 1) @(negedge clk);
      if (gap == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif

    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s done reached", tag), done, 1);
    @(negedge clk);

    check($sformatf("%s write count", tag), writes.size() - ws, exp_writes);
    for (int i = 0; i < eff; i++) begin
      exp_word = {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]};
      if (ws + i < writes.size()) begin
        check($sformatf("%s addr[%0d]", tag, i), writes[ws+i].addr, i % MAX_WORDS);
        check($sformatf("%s data[%0d]", tag, i), writes[ws+i].data, exp_word);
      end
    end
    check($sformatf("%s core_rst released", tag), core_rst, 0);
    check($sformatf("%s busy cleared", tag), busy, 0);
    check($sformatf("%s byte_ready in WRITE", tag), ready_in_write - rw, 0);
    if (eff > 0) begin
      exp_word = {payload[4*eff-4], payload[4*eff-3], payload[4*eff-2], payload[4*eff-1]};
      check($sformatf("%s imem_addr held", tag), ifc.imem_addr, (eff - 1) % MAX_WORDS);
      check($sformatf("%s imem_wdata held", tag), ifc.imem_wdata, exp_word);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check($sformatf("%s done one cycle after last write", tag),
            done_rise_cyc - last_we_cyc, 1);
`endif
    end
    payload.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    payload.push_back(w[31:24]);
    payload.push_back(w[23:16]);
    payload.push_back(w[15:8]);
    payload.push_back(w[7:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   ws, nw;

    vecs[0] = '{nw: 2,   gap: 0, glitch: -1, w0: 32'h20080005, w1: 32'h20090007, exp_writes: 2};
    vecs[1] = '{nw: 2,   gap: 1, glitch: -1, w0: 32'h20080005, w1: 32'h20090007, exp_writes: 2};
    vecs[2] = '{nw: 2,   gap: 2, glitch: 3,  w0: 32'hdeadbeef, w1: 32'h01234567, exp_writes: 2};
    vecs[3] = '{nw: 1,   gap: 0, glitch: -1, w0: 32'hffffffff, w1: 32'h0,        exp_writes: 1};
    vecs[4] = '{nw: 0,   gap: 0, glitch: -1, w0: 32'h0,        w1: 32'h0,        exp_writes: 0};
    vecs[5] = '{nw: 5,   gap: 2, glitch: 9,  w0: 32'h8c010004, w1: 32'hac020008, exp_writes: 5};
    vecs[6] = '{nw: 300, gap: 0, glitch: -1, w0: 32'h00000000, w1: 32'h11111111, exp_writes: 256};
    vecs[7] = '{nw: 256, gap: 0, glitch: -1, w0: 32'h3c1d1000, w1: 32'h03e00008, exp_writes: 256};

    rst            = 1'b1;
    start          = 1'b0;
    num_words      = '0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset core_rst", core_rst, 1);
    check("reset imem_we", ifc.imem_we, 0);
    check("reset byte_ready", ifc.byte_ready, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset error", error, 0);
    check("reset imem_addr", ifc.imem_addr, 0);
    check("reset imem_wdata", ifc.imem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].nw >= 1) push_word(vecs[v].w0);
      if (vecs[v].nw >= 2) push_word(vecs[v].w1);
      run_load(vecs[v].nw, vecs[v].gap, vecs[v].glitch, vecs[v].exp_writes,
               $sformatf("vec%0d", v));
    end

    // Reset in the middle of word 1: partial word dropped, core stays in reset.
    ws        = writes.size();
    start     = 1'b1;
    num_words = (ADDR_W + 1)'(2);
    @(negedge clk);
    start = 1'b0;
    push_word(32'h20080005);
    push_word(32'h20090007);
    for (int i = 0; i < 6; i++) send_byte(payload[i]);
    payload.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst core_rst", core_rst, 1);
    check("midrst byte_ready", ifc.byte_ready, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst imem_addr", ifc.imem_addr, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst writes issued", writes.size() - ws, 1);
    check("midrst still idle", busy, 0);
    push_word(32'h20080005);
    push_word(32'h20090007);
    run_load(2, 0, -1, 2, "after_midrst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: error, core held in reset, back to idle.
    start     = 1'b1;
    num_words = (ADDR_W + 1)'(1);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    check("cksum bad error", error, 1);
    check("cksum bad core_rst", core_rst, 1);
    check("cksum bad done", done, 0);
    check("cksum bad busy", busy, 0);
    push_word(32'h01020304);
    run_load(1, 0, -1, 1, "cksum_good");
`endif

    for (int r = 0; r < 4; r++) begin
      nw = $urandom_range(1, 6);
      run_load(nw, 2, -1, nw, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
